// File: rtl/gfx_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM graphics-ROM read port between pixel-pipeline clients.
// One queued request per client, one fetch in flight, watchdog on a lost memory acknowledge.
module gfx_rom_arbiter #(
    parameter int unsigned               NUM_CLIENTS = 3,
    parameter logic [25*NUM_CLIENTS-1:0] CLIENT_BASE = {NUM_CLIENTS{25'h0}},
    parameter int unsigned               TIMEOUT     = 255
) (
    input  logic                      CLK_32M,
    input  logic                      RESET_N,
    input  logic [NUM_CLIENTS-1:0]    CLIENT_REQ,
    input  logic [20*NUM_CLIENTS-1:0] CLIENT_ADDR,
    output logic [31:0]               CLIENT_DATA,
    output logic [NUM_CLIENTS-1:0]    CLIENT_RDY,
    output logic [24:0]               MEM_ADDR,
    output logic                      MEM_REQ,
    input  logic                      MEM_ACK,
    input  logic [31:0]               MEM_DATA,
    output logic                      TIMEOUT_ERR
);

    localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        last_grant_q;
    logic [9:0]             wdog_q;
    logic [NUM_CLIENTS-1:0] pending_q;
    logic [19:0]            addr_q [NUM_CLIENTS];

    logic [IdxW-1:0]        grant_idx;
    logic [IdxW-1:0]        cand;
    logic                   grant_found;
    logic                   issue;
    logic [24:0]            grant_addr;
    logic [NUM_CLIENTS-1:0] rdy_onehot;

    // First pending client searching upward from the one after the last grant.
    always_comb begin
        grant_idx   = '0;
        cand        = '0;
        grant_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % NUM_CLIENTS);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        issue      = (state_q == StIdle) && grant_found;
        grant_addr = CLIENT_BASE[25*grant_idx +: 25] + {3'b000, addr_q[grant_idx], 2'b00};
        rdy_onehot = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << last_grant_q;
    end

    // A fresh request always wins over the clear caused by issuing that slot.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q <= '0;
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (CLIENT_REQ[i]) begin
                    pending_q[i] <= 1'b1;
                    addr_q[i]    <= CLIENT_ADDR[20*i +: 20];
                end else if (issue && (grant_idx == IdxW'(i))) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(NUM_CLIENTS - 1);
            wdog_q       <= '0;
            MEM_ADDR     <= '0;
            MEM_REQ      <= 1'b0;
            CLIENT_DATA  <= '0;
            CLIENT_RDY   <= '0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            MEM_REQ     <= 1'b0;
            CLIENT_RDY  <= '0;
            TIMEOUT_ERR <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        MEM_ADDR     <= grant_addr;
                        MEM_REQ      <= 1'b1;
                        last_grant_q <= grant_idx;
                        wdog_q       <= '0;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (MEM_ACK) begin
                        CLIENT_DATA <= MEM_DATA;
                        CLIENT_RDY  <= rdy_onehot;
                        state_q     <= StIdle;
                    end else if ((wdog_q + 10'd1) == 10'(TIMEOUT)) begin
                        // Request is abandoned: no ready pulse for the client.
                        TIMEOUT_ERR <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 10'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Directed bench for gfx_rom_arbiter: vector table for fetch/round-robin timing,
// hand-written sequences for overwrite, re-request, watchdog and reset corner cases.
module tb_gfx_rom_arbiter;

    localparam int unsigned N = 3;
    localparam logic [74:0] BASE = {25'h0, 25'h100000, 25'h0};

    logic          CLK_32M = 1'b0;
    logic          RESET_N = 1'b0;
    logic [N-1:0]  CLIENT_REQ = '0;
    logic [59:0]   CLIENT_ADDR = '0;
    logic [31:0]   CLIENT_DATA;
    logic [N-1:0]  CLIENT_RDY;
    logic [24:0]   MEM_ADDR;
    logic          MEM_REQ;
    logic          MEM_ACK = 1'b0;
    logic [31:0]   MEM_DATA = '0;
    logic          TIMEOUT_ERR;

    gfx_rom_arbiter #(
        .NUM_CLIENTS (N),
        .CLIENT_BASE (BASE),
        .TIMEOUT     (4)
    ) dut (
        .CLK_32M     (CLK_32M),
        .RESET_N     (RESET_N),
        .CLIENT_REQ  (CLIENT_REQ),
        .CLIENT_ADDR (CLIENT_ADDR),
        .CLIENT_DATA (CLIENT_DATA),
        .CLIENT_RDY  (CLIENT_RDY),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_REQ     (MEM_REQ),
        .MEM_ACK     (MEM_ACK),
        .MEM_DATA    (MEM_DATA),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK_32M = ~CLK_32M;

    typedef struct {
        logic [2:0]  req;
        logic [59:0] addr;
        logic        ack;
        logic [31:0] mdata;
        logic        e_req;
        logic [24:0] e_addr;
        logic [2:0]  e_rdy;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] req, input logic [59:0] addr, input logic ack,
                       input logic [31:0] mdata, input logic e_req, input logic [24:0] e_addr,
                       input logic [2:0] e_rdy, input logic [31:0] e_data);
        vec_t v;
        v.req    = req;
        v.addr   = addr;
        v.ack    = ack;
        v.mdata  = mdata;
        v.e_req  = e_req;
        v.e_addr = e_addr;
        v.e_rdy  = e_rdy;
        v.e_data = e_data;
        v.e_err  = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] req, input logic [59:0] addr, input logic ack,
                         input logic [31:0] mdata);
        CLIENT_REQ  = req;
        CLIENT_ADDR = addr;
        MEM_ACK     = ack;
        MEM_DATA    = mdata;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic count_fetches(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (MEM_REQ) n++;
        end
    endtask

    initial begin
        int n;

        // Round 1 right after reset: grant order 0,1,2.
        add(3'b111, 60'h00003_00002_00001, 1'b0, 32'h0,        1'b0, 25'h0,      3'b000, 32'h0);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'h4,      3'b000, 32'h0);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h4,      3'b000, 32'h0);
        add(3'b000, 60'h0,                 1'b1, 32'hA0A0A0A0, 1'b0, 25'h4,      3'b001, 32'hA0A0A0A0);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'h100008, 3'b000, 32'hA0A0A0A0);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h100008, 3'b000, 32'hA0A0A0A0);
        add(3'b000, 60'h0,                 1'b1, 32'hA1A1A1A1, 1'b0, 25'h100008, 3'b010, 32'hA1A1A1A1);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'hC,      3'b000, 32'hA1A1A1A1);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'hC,      3'b000, 32'hA1A1A1A1);
        add(3'b000, 60'h0,                 1'b1, 32'hA2A2A2A2, 1'b0, 25'hC,      3'b100, 32'hA2A2A2A2);
        // Round 2: order 0,1,2 again.
        add(3'b111, 60'h00006_00005_00004, 1'b0, 32'h0,        1'b0, 25'hC,      3'b000, 32'hA2A2A2A2);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'h10,     3'b000, 32'hA2A2A2A2);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h10,     3'b000, 32'hA2A2A2A2);
        add(3'b000, 60'h0,                 1'b1, 32'hB0B0B0B0, 1'b0, 25'h10,     3'b001, 32'hB0B0B0B0);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'h100014, 3'b000, 32'hB0B0B0B0);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h100014, 3'b000, 32'hB0B0B0B0);
        add(3'b000, 60'h0,                 1'b1, 32'hB1B1B1B1, 1'b0, 25'h100014, 3'b010, 32'hB1B1B1B1);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'h18,     3'b000, 32'hB1B1B1B1);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h18,     3'b000, 32'hB1B1B1B1);
        add(3'b000, 60'h0,                 1'b1, 32'hB2B2B2B2, 1'b0, 25'h18,     3'b100, 32'hB2B2B2B2);
        // Single fetch for client 1, ack 3 cycles after MEM_REQ.
        add(3'b010, 60'h00000_00010_00000, 1'b0, 32'h0,        1'b0, 25'h18,     3'b000, 32'hB2B2B2B2);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b1, 25'h100040, 3'b000, 32'hB2B2B2B2);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h100040, 3'b000, 32'hB2B2B2B2);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h100040, 3'b000, 32'hB2B2B2B2);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h100040, 3'b000, 32'hB2B2B2B2);
        add(3'b000, 60'h0,                 1'b1, 32'hDEADBEEF, 1'b0, 25'h100040, 3'b010, 32'hDEADBEEF);
        add(3'b000, 60'h0,                 1'b0, 32'h0,        1'b0, 25'h100040, 3'b000, 32'hDEADBEEF);

        // Reset state.
        step();
        step();
        check("reset_mem_req", 32'(MEM_REQ), 32'h0);
        check("reset_mem_addr", 32'(MEM_ADDR), 32'h0);
        check("reset_rdy", 32'(CLIENT_RDY), 32'h0);
        check("reset_data", CLIENT_DATA, 32'h0);
        check("reset_err", 32'(TIMEOUT_ERR), 32'h0);
        RESET_N = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].ack, vecs[i].mdata);
            step();
            check($sformatf("vec%0d_mem_req", i), 32'(MEM_REQ), 32'(vecs[i].e_req));
            check($sformatf("vec%0d_mem_addr", i), 32'(MEM_ADDR), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_rdy", i), 32'(CLIENT_RDY), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_data", i), CLIENT_DATA, vecs[i].e_data);
            check($sformatf("vec%0d_err", i), 32'(TIMEOUT_ERR), 32'(vecs[i].e_err));
        end

        // Overwrite: client 2 requests addr 5 then 9 while client 0 is in flight.
        drive(3'b001, 60'h00000_00000_00020, 1'b0, 32'h0);
        step();
        drive(3'b100, 60'h00005_00000_00000, 1'b0, 32'h0);
        step();
        check("ovw_c0_req", 32'(MEM_REQ), 32'h1);
        check("ovw_c0_addr", 32'(MEM_ADDR), 32'h80);
        drive(3'b100, 60'h00009_00000_00000, 1'b0, 32'h0);
        step();
        drive(3'b000, 60'h0, 1'b1, 32'h11111111);
        step();
        check("ovw_c0_rdy", 32'(CLIENT_RDY), 32'h1);
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        step();
        check("ovw_c2_req", 32'(MEM_REQ), 32'h1);
        check("ovw_c2_addr", 32'(MEM_ADDR), 32'h24);
        drive(3'b000, 60'h0, 1'b1, 32'h22222222);
        step();
        check("ovw_c2_rdy", 32'(CLIENT_RDY), 32'h4);
        check("ovw_c2_data", CLIENT_DATA, 32'h22222222);
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        count_fetches(6, n);
        check("ovw_single_fetch", 32'(n), 32'h0);

        // Re-request on the in-flight client in the same cycle as its ack.
        drive(3'b001, 60'h00000_00000_00030, 1'b0, 32'h0);
        step();
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        step();
        check("rereq_first_req", 32'(MEM_REQ), 32'h1);
        check("rereq_first_addr", 32'(MEM_ADDR), 32'hC0);
        drive(3'b001, 60'h00000_00000_00031, 1'b1, 32'h33333333);
        step();
        check("rereq_rdy", 32'(CLIENT_RDY), 32'h1);
        check("rereq_no_req_yet", 32'(MEM_REQ), 32'h0);
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        step();
        check("rereq_second_req", 32'(MEM_REQ), 32'h1);
        check("rereq_second_addr", 32'(MEM_ADDR), 32'hC4);
        drive(3'b000, 60'h0, 1'b1, 32'h44444444);
        step();
        check("rereq_second_rdy", 32'(CLIENT_RDY), 32'h1);
        check("rereq_second_data", CLIENT_DATA, 32'h44444444);

        // Watchdog: no ack, expiry 4 cycles after MEM_REQ, then a late ack in IDLE.
        drive(3'b010, 60'h00000_00001_00000, 1'b0, 32'h0);
        step();
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        step();
        check("wd_req", 32'(MEM_REQ), 32'h1);
        check("wd_addr", 32'(MEM_ADDR), 32'h100004);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("wd_err_c%0d", k), 32'(TIMEOUT_ERR), (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("wd_rdy_c%0d", k), 32'(CLIENT_RDY), 32'h0);
        end
        step();
        check("wd_err_single", 32'(TIMEOUT_ERR), 32'h0);
        drive(3'b000, 60'h0, 1'b1, 32'h55555555);
        step();
        check("wd_late_ack_rdy", 32'(CLIENT_RDY), 32'h0);
        check("wd_late_ack_data", CLIENT_DATA, 32'h44444444);
        drive(3'b000, 60'h0, 1'b0, 32'h0);

        // Reset mid-WAIT with another client queued.
        drive(3'b100, 60'h00007_00000_00000, 1'b0, 32'h0);
        step();
        drive(3'b001, 60'h00000_00000_00001, 1'b0, 32'h0);
        step();
        check("rst_pre_req", 32'(MEM_REQ), 32'h1);
        check("rst_pre_addr", 32'(MEM_ADDR), 32'h1C);
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        RESET_N = 1'b0;
        #1;
        check("rst_async_req", 32'(MEM_REQ), 32'h0);
        check("rst_async_addr", 32'(MEM_ADDR), 32'h0);
        check("rst_async_data", CLIENT_DATA, 32'h0);
        check("rst_async_rdy", 32'(CLIENT_RDY), 32'h0);
        check("rst_async_err", 32'(TIMEOUT_ERR), 32'h0);
        step();
        RESET_N = 1'b1;
        drive(3'b000, 60'h0, 1'b1, 32'h66666666);
        step();
        check("rst_ack_rdy", 32'(CLIENT_RDY), 32'h0);
        check("rst_ack_data", CLIENT_DATA, 32'h0);
        drive(3'b000, 60'h0, 1'b0, 32'h0);
        count_fetches(5, n);
        check("rst_pending_cleared", 32'(n), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gfx_rom_arbiter.md
# gfx_rom_arbiter

Shares one SDRAM graphics-ROM read port between the tile layers and other pixel-pipeline ROM clients, and sits directly upstream of each layer's `sdr_req`/`sdr_addr`/`sdr_data`/`sdr_rdy` interface. Each client issues single-cycle 32-bit fetch requests. The arbiter queues one request per client, serialises the requests to memory in round-robin order, and returns the data with a per-client ready pulse. A watchdog prevents a lost memory acknowledge from stalling the video pipeline.

## Interface
Parameters:
- `NUM_CLIENTS`, 3, number of requesting layers (2..8).
- `CLIENT_BASE`, {NUM_CLIENTS{25'h0}}, packed 25-bit byte base address per client. Client i occupies bits [25*i+24:25*i].
- `TIMEOUT`, 255, maximum cycles to wait for `MEM_ACK` (1..1023).

Ports:
- `CLK_32M` in 1: system clock. All logic is on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `CLIENT_REQ` in NUM_CLIENTS: one-cycle request strobe per client.
- `CLIENT_ADDR` in 20*NUM_CLIENTS: 32-bit word address per client. Client i occupies bits [20*i+19:20*i].
- `CLIENT_DATA` out 32: shared return data. Valid when any `CLIENT_RDY` bit is high.
- `CLIENT_RDY` out NUM_CLIENTS: one-cycle completion pulse. At most one bit is high per cycle.
- `MEM_ADDR` out 25: byte address to the SDRAM controller.
- `MEM_REQ` out 1: one-cycle request strobe to the SDRAM controller.
- `MEM_ACK` in 1: one-cycle data-valid strobe from the SDRAM controller.
- `MEM_DATA` in 32: read data, sampled when `MEM_ACK` is high.
- `TIMEOUT_ERR` out 1: one-cycle pulse when a watchdog expiry abandons a request.

## Operation
Per-client slot:
- Each client has a `pending` flag and a 20-bit latched address.
- `CLIENT_REQ[i]` sets `pending[i]` and captures `CLIENT_ADDR[i]`.
- A new request on a slot that is already pending but not yet issued overwrites the address. The latest request wins and only one fetch results.
- A new request on the client currently in flight sets `pending` again. The in-flight result is still delivered, followed later by the new one.
- Issuing a request clears `pending[i]`, unless `CLIENT_REQ[i]` is high in the same cycle.

FSM states:
- IDLE:
  - If any `pending` bit is set, grant the first pending client searching upward from `last_grant+1`, wrapping modulo NUM_CLIENTS.
  - On grant: register `MEM_ADDR` = `CLIENT_BASE[g]` + {`addr[g]`, 2'b00}, computed in 25 bits with the carry discarded. Pulse `MEM_REQ`, set `last_grant` = g, clear the watchdog, then go to WAIT.
- WAIT:
  - On `MEM_ACK`: register `CLIENT_DATA` = `MEM_DATA`, pulse `CLIENT_RDY[g]`, then go to IDLE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, pulse `TIMEOUT_ERR`, leave `CLIENT_RDY` low (the request is dropped), then go to IDLE.
- `MEM_ACK` received in IDLE is ignored.

Reset (`RESET_N` low, asynchronous, any state including mid-WAIT):
- State goes to IDLE, `last_grant` = NUM_CLIENTS-1, and all `pending` bits are cleared.
- `MEM_REQ`, `CLIENT_RDY` and `TIMEOUT_ERR` go to 0.
- `MEM_ADDR` and `CLIENT_DATA` go to 0.
- An acknowledge arriving after reset release is ignored.

## Timing
- A request sampled at edge N sets `pending` at N. The grant is made at edge N+1 if the FSM is in IDLE, so `MEM_REQ` is high for the cycle following N+1.
- An acknowledge sampled at edge M drives `CLIENT_RDY`/`CLIENT_DATA` valid for the cycle following M. The next grant can occur at edge M+1.
- Minimum turnaround is 2 cycles plus memory latency. Back-to-back fetches are spaced at least 2 cycles apart per `MEM_REQ`.
- `MEM_ADDR` is stable from the `MEM_REQ` cycle until the next grant.
- `CLIENT_DATA` holds its value until the next `MEM_ACK`.
- Fairness: with all clients continuously pending, each client is served once every NUM_CLIENTS fetches.

## Test plan
- Single fetch, `CLIENT_BASE[1]`=25'h100000: `CLIENT_REQ[1]` with addr 20'h00010, `MEM_ACK` 3 cycles after `MEM_REQ` with 32'hDEADBEEF -> `MEM_ADDR`=25'h100040, then `CLIENT_RDY`=3'b010 for one cycle with `CLIENT_DATA`=32'hDEADBEEF. Total latency 2+3 cycles.
- Simultaneous `CLIENT_REQ`=3'b111 after reset -> grant order 0,1,2. A second round of 3'b111 -> order 0,1,2 again.
- Overwrite: client 2 requests addr 5 then addr 9 while client 0 is in flight -> exactly one fetch for client 2, at `MEM_ADDR`={9,2'b00}.
- Re-request in flight: client 0 requests again in the same cycle as its `MEM_ACK` -> `RDY[0]` pulses, and a second `MEM_REQ` for client 0 follows one cycle later.
- Watchdog, TIMEOUT=4: no `MEM_ACK` -> `TIMEOUT_ERR` pulses 4 cycles after `MEM_REQ` and no `RDY`. A late `MEM_ACK` arriving in IDLE produces no `RDY`.
- Reset mid-WAIT: `RESET_N` low for 1 cycle -> all outputs 0 immediately. `pending` is cleared, and a `MEM_ACK` after release gives no `RDY`.
